// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision field widths, result flag positions and converter states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package fp32_pkg;

    localparam int FP32_EXP_W   = 8;
    localparam int FP32_FRAC_W  = 23;
    localparam int FP32_BIAS    = 127;
    localparam int FP32_EXP_MAX = 255;

    // Bit positions inside the 3-bit {invalid, overflow, inexact} flag vector
    localparam int FLG_INVALID  = 2;
    localparam int FLG_OVERFLOW = 1;
    localparam int FLG_INEXACT  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OUT   = 2'd2
    } conv_state_t;

endpackage

// File: rtl/fp32_align_step.sv
// One alignment step: shifts the magnitude by min(STEP, remaining) toward the integer point.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module fp32_align_step #(
    parameter int MAG_W = 32,
    parameter int REM_W = 6,
    parameter int STEP  = 4
) (
    input  logic [MAG_W-1:0] mag_in,
    input  logic             dir_left,
    input  logic [REM_W-1:0] rem_in,
    input  logic             sticky_in,
    output logic [MAG_W-1:0] mag_out,
    output logic [REM_W-1:0] rem_out,
    output logic             sticky_out
);
    import fp32_pkg::*;

    localparam logic [REM_W-1:0] STEP_R = REM_W'(STEP);

    logic [REM_W-1:0] k;
    logic [MAG_W-1:0] lost_mask;

    assign k         = (rem_in > STEP_R) ? STEP_R : rem_in;
    // Low k bits fall off the bottom on a right shift; they only feed the sticky bit
    assign lost_mask = ~({MAG_W{1'b1}} << k);

    assign mag_out    = dir_left ? (mag_in << k) : (mag_in >> k);
    assign rem_out    = rem_in - k;
    assign sticky_out = sticky_in | (~dir_left & (|(mag_in & lost_mask)));

endmodule

// File: rtl/fp32_to_int_converter.sv
// FP32 -> signed INT_W conversion, round toward zero, multi-cycle alignment shifter.
// Latency: 1 cycle for specials/zero shift, else 1+ceil(n/STEP) cycles accept->out_valid.
// Backpressure: one operation in flight; in_ready only in IDLE, result held until out_ready.
module fp32_to_int_converter #(
    parameter int INT_W = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_data,
    output logic [2:0]       out_flags
);
    import fp32_pkg::*;

    // Mantissa is 24 bits; the magnitude register must hold it even for narrow results
    localparam int MAG_W = (INT_W > 24) ? INT_W : 24;
    localparam int REM_W = 6;

    localparam logic [7:0] EXP_MAX8 = 8'(FP32_EXP_MAX);
    localparam logic [7:0] BIAS8    = 8'(FP32_BIAS);
    localparam logic [7:0] E_UNIT   = 8'(FP32_BIAS + FP32_FRAC_W);  // exponent where M needs no shift
    localparam logic [7:0] E_SAT    = 8'(FP32_BIAS + INT_W - 1);    // first exponent out of range

    localparam logic [INT_W-1:0] MIN_INT = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic [INT_W-1:0] MAX_INT = ~MIN_INT;

    conv_state_t      state;
    logic [MAG_W-1:0] mag_q;
    logic             dir_q;
    logic [REM_W-1:0] rem_q;
    logic             sticky_q;
    logic             sign_q;

    logic [MAG_W-1:0] mag_nx;
    logic [REM_W-1:0] rem_nx;
    logic             sticky_nx;

    logic             in_sign;
    logic [7:0]       in_exp;
    logic [22:0]      in_frac;
    logic [7:0]       shamt;
    logic             dec_done;
    logic [INT_W-1:0] dec_data;
    logic [2:0]       dec_flags;
    logic [MAG_W-1:0] dec_mag;
    logic             dec_dir;
    logic [REM_W-1:0] dec_rem;
    logic [2:0]       shift_flags;

    function automatic logic [INT_W-1:0] apply_sign(input logic s, input logic [INT_W-1:0] m);
        return s ? -m : m;
    endfunction

    assign in_ready = (state == IDLE);

    assign in_sign = in_data[31];
    assign in_exp  = in_data[30:23];
    assign in_frac = in_data[22:0];

    fp32_align_step #(
        .MAG_W (MAG_W),
        .REM_W (REM_W),
        .STEP  (STEP)
    ) u_align (
        .mag_in     (mag_q),
        .dir_left   (dir_q),
        .rem_in     (rem_q),
        .sticky_in  (sticky_q),
        .mag_out    (mag_nx),
        .rem_out    (rem_nx),
        .sticky_out (sticky_nx)
    );

    // Classify the incoming float: finish immediately for specials/no-shift, else set up the shifter
    always_comb begin
        dec_done    = 1'b1;
        dec_data    = '0;
        dec_flags   = '0;
        dec_mag     = MAG_W'({1'b1, in_frac});
        shamt       = (in_exp > E_UNIT) ? (in_exp - E_UNIT) : (E_UNIT - in_exp);
        dec_dir     = (in_exp > E_UNIT);
        dec_rem     = shamt[REM_W-1:0];
        shift_flags = '0;
        shift_flags[FLG_INEXACT] = sticky_nx;

        if (in_exp == EXP_MAX8) begin
            if (in_frac != '0) begin
                dec_data               = MIN_INT;
                dec_flags[FLG_INVALID] = 1'b1;
            end else begin
                dec_data                = in_sign ? MIN_INT : MAX_INT;
                dec_flags[FLG_OVERFLOW] = 1'b1;
            end
        end else if (in_exp < BIAS8) begin
            // |x| < 1 truncates to zero; only a true zero is exact
            dec_flags[FLG_INEXACT] = (in_exp != '0) || (in_frac != '0);
        end else if (in_exp >= E_SAT) begin
            if (in_sign && (in_exp == E_SAT) && (in_frac == '0)) begin
                dec_data = MIN_INT;
            end else begin
                dec_data                = in_sign ? MIN_INT : MAX_INT;
                dec_flags[FLG_OVERFLOW] = 1'b1;
            end
        end else if (in_exp == E_UNIT) begin
            dec_data = apply_sign(in_sign, dec_mag[INT_W-1:0]);
        end else begin
            dec_done = 1'b0;
        end
    end

    // Converter FSM: accept in IDLE, step the shifter in SHIFT, hold the result in OUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mag_q     <= '0;
            dir_q     <= 1'b0;
            rem_q     <= '0;
            sticky_q  <= 1'b0;
            sign_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= in_sign;
                        mag_q    <= dec_mag;
                        dir_q    <= dec_dir;
                        rem_q    <= dec_rem;
                        sticky_q <= 1'b0;
                        if (dec_done) begin
                            out_data  <= dec_data;
                            out_flags <= dec_flags;
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    mag_q    <= mag_nx;
                    rem_q    <= rem_nx;
                    sticky_q <= sticky_nx;
                    // Last step: sign is applied as the result is registered
                    if (rem_nx == '0) begin
                        out_data  <= apply_sign(sign_q, mag_nx[INT_W-1:0]);
                        out_flags <= shift_flags;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_to_int_converter.sv
module tb_fp32_to_int_converter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_flags;

    int checks = 0;
    int errors = 0;

    fp32_to_int_converter #(.INT_W(32), .STEP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact value of the float, truncated, range-checked against int32
    task automatic model(input logic [31:0] f, output logic [31:0] d, output logic [2:0] fl,
                         output int lat);
        logic        s;
        int          e;
        int          ex;
        int          n;
        longint      m;
        longint      ip;
        longint      val;
        logic        frac_nz;
        s  = f[31];
        e  = int'(f[30:23]);
        m  = longint'({1'b1, f[22:0]});
        lat = 1;
        fl = 3'b000;
        d  = 32'd0;
        if (e == 255) begin
            if (f[22:0] != 0) begin d = 32'h8000_0000; fl = 3'b100; end
            else begin d = s ? 32'h8000_0000 : 32'h7FFF_FFFF; fl = 3'b010; end
        end else if (e < 127) begin
            fl = (f[30:0] != 0) ? 3'b001 : 3'b000;
        end else begin
            ex = e - 127;
            if (ex >= 40) begin
                d = s ? 32'h8000_0000 : 32'h7FFF_FFFF; fl = 3'b010;
            end else begin
                if (ex >= 23) begin
                    ip = m << (ex - 23);
                    frac_nz = 1'b0;
                    n = ex - 23;
                end else begin
                    ip = m >> (23 - ex);
                    frac_nz = ((ip << (23 - ex)) != m);
                    n = 23 - ex;
                end
                val = s ? -ip : ip;
                if (val > 64'sd2147483647 || val < -64'sd2147483648) begin
                    d = s ? 32'h8000_0000 : 32'h7FFF_FFFF; fl = 3'b010;
                end else begin
                    d  = val[31:0];
                    fl = {2'b00, frac_nz};
                end
                if (ex < 31 && n != 0) lat = 1 + (n + 3) / 4;
            end
        end
    endtask

    // Push one float, measure latency, optionally stall the consumer, then complete the handshake
    task automatic run_one(input string tag, input logic [31:0] f, input logic [31:0] exp_d,
                           input logic [2:0] exp_fl, input int exp_lat, input int hold);
        int lat;
        @(posedge clk); #1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = f;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_data"},    64'(out_data),  64'(exp_d));
        chk({tag, "_flags"},   64'(out_flags), 64'(exp_fl));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_data"},  64'(out_data),  64'(exp_d));
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_ready"}, 64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    endtask

    typedef struct {
        logic [31:0] f;
        logic [31:0] d;
        logic [2:0]  fl;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] f;
        logic [31:0] d;
        logic [2:0]  fl;
        int          lat;
        int          sel;

        vecs[0] = '{32'h3FC0_0000, 32'h0000_0001, 3'b001, 7};
        vecs[1] = '{32'hC2F6_E979, 32'hFFFF_FF85, 3'b001, 6};
        vecs[2] = '{32'h4B00_0001, 32'd8388609,   3'b000, 1};
        vecs[3] = '{32'h4F00_0000, 32'h7FFF_FFFF, 3'b010, 1};
        vecs[4] = '{32'hCF00_0000, 32'h8000_0000, 3'b000, 1};
        vecs[5] = '{32'h7FC0_0000, 32'h8000_0000, 3'b100, 1};
        vecs[6] = '{32'hFF80_0000, 32'h8000_0000, 3'b010, 1};
        vecs[7] = '{32'h0000_0001, 32'h0000_0000, 3'b001, 1};
        vecs[8] = '{32'h8000_0000, 32'h0000_0000, 3'b000, 1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_flags", 64'(out_flags), 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_one($sformatf("dir%0d", i), vecs[i].f, vecs[i].d, vecs[i].fl, vecs[i].lat, 0);

        // Consumer stalls five cycles on a long shift
        run_one("backpressure", 32'h3FC0_0000, 32'h0000_0001, 3'b001, 7, 5);

        // Reset lands in the middle of the shift sequence
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 32'h3FC0_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("midshift_busy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_out_valid", 64'(out_valid), 64'd0);
        chk("postrst_in_ready",  64'(in_ready),  64'd1);
        chk("postrst_out_data",  64'(out_data),  64'd0);
        run_one("after_reset", 32'hC2F6_E979, 32'hFFFF_FF85, 3'b001, 6, 1);

        // Random floats, weighted toward exponents near the integer range
        for (int t = 0; t < 200; t++) begin
            sel = $urandom_range(0, 3);
            f   = $urandom;
            if (sel != 0) f[30:23] = 8'($urandom_range(120, 160));
            if ($urandom_range(0, 7) == 0) f[22:0] = '0;
            model(f, d, fl, lat);
            run_one($sformatf("rnd%0d_%08h", t, f), f, d, fl, lat, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
